fmac_pe_sequencer: RTL and testbench

//  Sequences a bank of fmac processing elements (PEs) through one convolution pass.

---
 rtl/fmac_seq_pkg.sv | 18 +
 rtl/fmac_onehot_ring.sv | 23 ++
 rtl/fmac_pe_sequencer.sv | 101 ++++++++++
 tb/tb_fmac_pe_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fmac_seq_pkg.sv
// Shared types and defaults for the fmac PE sequencer.
// Optional stall input is enabled by defining FMAC_SEQ_STALL_EN.
package fmac_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_e;

  localparam int N_STATES_DEF     = 8;
  localparam int NUM_PES_DEF      = 4;
  localparam int ITER_W_DEF       = 16;
  localparam int DRAIN_CYCLES_DEF = 3;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction
endpackage

// File: rtl/fmac_onehot_ring.sv
// One-hot state ring: load bit0, rotate left, clear; flags last bit and one-hot legality.
module fmac_onehot_ring #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  output logic [N-1:0] ring,
  output logic         last,
  output logic         onehot
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ring <= '0;
    else if (clear) ring <= '0;
    else if (load)  ring <= N'(1);
    else if (shift) ring <= {ring[N-2:0], ring[N-1]};
  end

  assign last   = ring[N-1];
  assign onehot = (ring != '0) && ((ring & (ring - N'(1))) == '0);
endmodule

// File: rtl/fmac_pe_sequencer.sv
// Drives the fmac PE array through n_iters tiles of one-hot states, drains the pipeline, pulses done.
// Define FMAC_SEQ_STALL_EN to add a stall input that freezes RUN/DRAIN progress.
module fmac_pe_sequencer
  import fmac_seq_pkg::*;
#(
  parameter int N_STATES     = N_STATES_DEF,
  parameter int NUM_PES      = NUM_PES_DEF,
  parameter int ITER_W       = ITER_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef FMAC_SEQ_STALL_EN
  input  logic                stall,
`endif
  input  logic                start,
  input  logic [ITER_W-1:0]   n_iters,
  input  logic                abort,
  output logic                busy,
  output logic [N_STATES-1:0] fsm_state,
  output logic [NUM_PES-1:0]  pe_ce,
  output logic [ITER_W-1:0]   iter_idx,
  output logic                done
);
  localparam int             DCW       = cnt_w(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_MAX = DCW'(DRAIN_CYCLES);
  localparam logic [ITER_W:0] ONE      = (ITER_W+1)'(1);

  seq_state_e        state;
  logic [ITER_W-1:0] n_q, iter_q;
  logic [DCW-1:0]    drain_q;
  logic              adv, last, onehot, illegal, abort_hit, last_iter;
  logic              ring_load, ring_shift, ring_clear;

`ifdef FMAC_SEQ_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  // Extra bit keeps iter+1 from wrapping when n_iters is all ones.
  assign last_iter = ({1'b0, iter_q} + ONE) >= {1'b0, n_q};
  assign abort_hit = abort && (state != IDLE);
  // Ring must be one-hot in RUN and empty elsewhere; anything else is corruption.
  assign illegal   = (state == RUN) ? !onehot : (fsm_state != '0);

  assign ring_clear = abort_hit || illegal || ((state == RUN) && adv && last && last_iter);
  assign ring_load  = (state == IDLE) && start && (n_iters != '0) && !illegal;
  assign ring_shift = (state == RUN) && adv;

  fmac_onehot_ring #(.N(N_STATES)) u_ring (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (ring_load),
    .shift  (ring_shift),
    .clear  (ring_clear),
    .ring   (fsm_state),
    .last   (last),
    .onehot (onehot)
  );

  // DRAIN walks drain_q 0..DRAIN_CYCLES and leaves on the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      n_q     <= '0;
      iter_q  <= '0;
      drain_q <= '0;
    end else if (abort_hit || illegal) begin
      state   <= IDLE;
      drain_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          iter_q <= '0;
          n_q    <= n_iters;
          state  <= (n_iters != '0) ? RUN : DONE;
        end
        RUN: if (adv && last) begin
          if (last_iter) begin
            state   <= DRAIN;
            drain_q <= '0;
          end else begin
            iter_q <= iter_q + ITER_W'(1);
          end
        end
        DRAIN: if (adv) begin
          if (drain_q == DRAIN_MAX) state <= DONE;
          else drain_q <= drain_q + DCW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign pe_ce    = {NUM_PES{busy && adv}};
  assign iter_idx = iter_q;
endmodule

// File: tb/tb_fmac_pe_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs, a negedge monitor pops on busy/done.
module tb_fmac_pe_sequencer;
  localparam int N = 8, P = 4, W = 16, D = 3;

  typedef struct packed {
    logic [N-1:0] fsm;
    logic [P-1:0] pe;
    logic [W-1:0] iter;
    logic         busy;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n, start, abort;
  logic [W-1:0] n_iters;
  logic         busy, done;
  logic [N-1:0] fsm_state;
  logic [P-1:0] pe_ce;
  logic [W-1:0] iter_idx;
`ifdef FMAC_SEQ_STALL_EN
  logic         stall;
`endif

  exp_t sb[$];
  exp_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;

  fmac_pe_sequencer #(.N_STATES(N), .NUM_PES(P), .ITER_W(W), .DRAIN_CYCLES(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef FMAC_SEQ_STALL_EN
    .stall    (stall),
`endif
    .start    (start),
    .n_iters  (n_iters),
    .abort    (abort),
    .busy     (busy),
    .fsm_state(fsm_state),
    .pe_ce    (pe_ce),
    .iter_idx (iter_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && (busy || done)) begin
      checks++;
      mon_got.fsm  = fsm_state;
      mon_got.pe   = pe_ce;
      mon_got.iter = iter_idx;
      mon_got.busy = busy;
      mon_got.done = done;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output fsm=%h pe=%h iter=%0d busy=%b done=%b",
                 fsm_state, pe_ce, iter_idx, busy, done);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL cycle_out got fsm=%h pe=%h iter=%0d busy=%b done=%b want fsm=%h pe=%h iter=%0d busy=%b done=%b",
                   mon_got.fsm, mon_got.pe, mon_got.iter, mon_got.busy, mon_got.done,
                   mon_exp.fsm, mon_exp.pe, mon_exp.iter, mon_exp.busy, mon_exp.done);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  // Expected outputs for cycle c (1 = first cycle after the accepted start).
  function automatic exp_t nominal(input int c, input int n);
    exp_t e;
    e = '0;
    if (n == 0) begin
      e.done = 1'b1;
    end else if (c <= n * N) begin
      e.fsm  = N'(1) << ((c - 1) % N);
      e.iter = W'((c - 1) / N);
      e.pe   = '1;
      e.busy = 1'b1;
    end else if (c <= n * N + D + 1) begin
      e.iter = W'(n - 1);
      e.pe   = '1;
      e.busy = 1'b1;
    end else begin
      e.iter = W'(n - 1);
      e.done = 1'b1;
    end
    return e;
  endfunction

  // keep < 0 pushes the whole run; stall_len frozen copies precede cycle stall_at.
  task automatic push_run(input int n, input int keep, input int stall_at, input int stall_len);
    int   total, pushed;
    exp_t e, s;
    total  = (n == 0) ? 1 : n * N + D + 2;
    pushed = 0;
    for (int c = 1; c <= total; c++) begin
      e = nominal(c, n);
      if (c == stall_at) begin
        s    = e;
        s.pe = '0;
        for (int k = 0; k < stall_len; k++) begin
          if (keep >= 0 && pushed >= keep) return;
          sb.push_back(s);
          pushed++;
        end
      end
      if (keep >= 0 && pushed >= keep) return;
      sb.push_back(e);
      pushed++;
    end
  endtask

  // Leaves the caller 1 time unit into cycle 1.
  task automatic issue(input int n);
    @(posedge clk); #1;
    start   = 1'b1;
    n_iters = W'(n);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout got=%0d_pending want=0", nm, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {8'(fsm_state), 4'(pe_ce), 1'(busy), 1'(done)}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; n_iters = '0;
`ifdef FMAC_SEQ_STALL_EN
    stall = 1'b0;
`endif
    #12;
    chk_idle("reset_outputs");
    chk("reset_iter", 32'(iter_idx), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // single tile: 8 states, drain, done 13 cycles after start
    push_run(1, -1, 0, 0);
    issue(1);
    wait_drain("run_n1");

    // three tiles, seamless wraps; iter_idx holds final value afterwards
    push_run(3, -1, 0, 0);
    issue(3);
    wait_drain("run_n3");
    chk("iter_hold", 32'(iter_idx), 32'd2);

    // zero iterations: straight to DONE
    push_run(0, -1, 0, 0);
    issue(0);
    wait_drain("run_n0");
    chk_idle("n0_idle");

    // abort at fsm_state 0x10 in iteration 1 (cycle 13)
    push_run(3, 13, 0, 0);
    issue(3);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_abort_state", 32'(fsm_state), 32'h10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_idle("post_abort");
    wait_drain("abort_run");
    push_run(1, -1, 0, 0);
    issue(1);
    wait_drain("after_abort");

    // start while busy must be ignored
    push_run(2, -1, 0, 0);
    issue(2);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; n_iters = W'(5);
    @(posedge clk); #1;
    start = 1'b0; n_iters = W'(2);
    wait_drain("busy_start");

    // asynchronous reset in the middle of DRAIN
    push_run(1, 9, 0, 0);
    issue(1);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_iter", 32'(iter_idx), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_drain("reset_run");
    chk_idle("post_reset_idle");

`ifdef FMAC_SEQ_STALL_EN
    // 4-cycle stall at fsm_state 0x04 delays done by exactly 4 cycles
    push_run(1, -1, 3, 4);
    issue(1);
    repeat (2) @(posedge clk);
    #1;
    stall = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_drain("stall_run");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
